// File: rtl/data_path_pkg.sv
// Shared widths and ALU opcodes for the Mini-SRC datapath.
package data_path_pkg;

  localparam int DW     = 32;
  localparam int MEM_AW = 9;

  localparam logic [4:0] OP_ADD0 = 5'b00000;
  localparam logic [4:0] OP_ADD1 = 5'b00001;
  localparam logic [4:0] OP_ADD2 = 5'b00010;
  localparam logic [4:0] OP_ADD3 = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND0 = 5'b01010;
  localparam logic [4:0] OP_OR0  = 5'b01011;
  localparam logic [4:0] OP_ADD4 = 5'b01100;
  localparam logic [4:0] OP_AND1 = 5'b01101;
  localparam logic [4:0] OP_OR1  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU: A=Y, B=bus, 64-bit result.
// Mul/div results fill all 64 bits; every other op is sign-extended.
module data_path_alu
  import data_path_pkg::*;
(
  input  logic [4:0]      i_op,
  input  logic [DW-1:0]   i_a,
  input  logic [DW-1:0]   i_b,
  output logic [2*DW-1:0] o_res
);

  logic [4:0]           w_sh;
  logic [DW-1:0]        w_lo;
  logic                 w_ext;
  logic [2*DW-1:0]      w_rr;
  logic [2*DW-1:0]      w_rl;
  logic signed [2*DW-1:0] w_prod;
  logic signed [DW-1:0] w_sa;
  logic signed [DW-1:0] w_sb;
  logic signed [DW-1:0] w_q;
  logic signed [DW-1:0] w_r;

  assign w_sh   = i_b[4:0];
  assign w_sa   = $signed(i_a);
  assign w_sb   = $signed(i_b);
  assign w_rr   = {i_a, i_a} >> w_sh;
  assign w_rl   = {i_a, i_a} << w_sh;
  assign w_prod = $signed({{DW{i_a[DW-1]}}, i_a})
                * $signed({{DW{i_b[DW-1]}}, i_b});

  always_comb begin
    w_q = '0;
    w_r = '0;
    if (i_b != '0) begin
      w_q = w_sa / w_sb;
      w_r = w_sa % w_sb;
    end
  end

  always_comb begin
    w_lo  = '0;
    w_ext = 1'b1;
    o_res = '0;
    case (i_op)
      OP_ADD0, OP_ADD1, OP_ADD2,
      OP_ADD3, OP_ADD4: w_lo = i_a + i_b;
      OP_SUB:           w_lo = i_a - i_b;
      OP_SHR:           w_lo = i_a >> w_sh;
      OP_SHRA:          w_lo = w_sa >>> w_sh;
      OP_SHL:           w_lo = i_a << w_sh;
      OP_ROR:           w_lo = w_rr[DW-1:0];
      OP_ROL:           w_lo = w_rl[2*DW-1:DW];
      OP_AND0, OP_AND1: w_lo = i_a & i_b;
      OP_OR0, OP_OR1:   w_lo = i_a | i_b;
      OP_NEG:           w_lo = '0 - i_b;
      OP_NOT:           w_lo = ~i_b;
      OP_MUL: begin
        w_ext = 1'b0;
        o_res = w_prod;
      end
      OP_DIV: begin
        w_ext = 1'b0;
        o_res = {w_r, w_q};
      end
      default:          w_lo = '0;
    endcase
    if (w_ext)
      o_res = {{DW{w_lo[DW-1]}}, w_lo};
  end

endmodule

// File: rtl/data_path.sv
// Mini-SRC single-bus datapath: regfile, PC/IR/MAR/MDR, Y/Z, HI/LO, CON, RAM.
// Externally sequenced; internal state is observed hierarchically.
module data_path
  import data_path_pkg::*;
(
  input  logic          clk,
  input  logic          clr,
  input  logic [4:0]    alu_control,
  input  logic [DW-1:0] Mdatain,
  input  logic R0out,  input logic R1out,  input logic R2out,  input logic R3out,
  input  logic R4out,  input logic R5out,  input logic R6out,  input logic R7out,
  input  logic R8out,  input logic R9out,  input logic R10out, input logic R11out,
  input  logic R12out, input logic R13out, input logic R14out, input logic R15out,
  input  logic MDROut, input logic HIout,  input logic LOout,  input logic ZHIout,
  input  logic ZLOout, input logic Pout,   input logic Cout,   input logic Yout,
  input  logic IRen,   input logic MARen,  input logic MDRen,  input logic Yen,
  input  logic Pen,    input logic ZHIen,  input logic ZLOen,  input logic HIen,
  input  logic LOen,
  input  logic Read,
  input  logic Write,
  input  logic R0en,   input logic R1en,   input logic R2en,   input logic R3en,
  input  logic R4en,   input logic R5en,   input logic R6en,   input logic R7en,
  input  logic R8en,   input logic R9en,   input logic R10en,  input logic R11en,
  input  logic R12en,  input logic R13en,  input logic R14en,  input logic R15en,
  input  logic Gra,
  input  logic Grb,
  input  logic Grc,
  input  logic BAout,
  input  logic ConIn,
  input  logic Rin,
  input  logic Rout
);

  logic [DW-1:0]   r [0:15];
  logic [DW-1:0]   pc, ir, mar, mdr, y, hi, lo;
  logic [2*DW-1:0] z;
  logic            con;
  logic [DW-1:0]   bus;
  logic [DW-1:0]   ram [0:(1<<MEM_AW)-1];

  logic [3:0]      w_sel;
  logic [15:0]     w_dec;
  logic [15:0]     w_rout;
  logic [15:0]     w_ren;
  logic [15:0]     w_rdrv;
  logic [DW-1:0]   w_rbus;
  logic [DW-1:0]   w_c;
  logic [2*DW-1:0] w_res;
  logic [DW-1:0]   w_ramrd;
  logic            w_cond;
  logic            w_unused;

  assign w_sel = ({4{Gra}} & ir[26:23])
               | ({4{Grb}} & ir[22:19])
               | ({4{Grc}} & ir[18:15]);
  assign w_dec = 16'd1 << w_sel;

  assign w_rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                   R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
  assign w_ren  = {R15en, R14en, R13en, R12en, R11en, R10en, R9en, R8en,
                   R7en,  R6en,  R5en,  R4en,  R3en,  R2en,  R1en, R0en}
                | ({16{Rin}} & w_dec);
  assign w_rdrv = w_rout | ({16{Rout | BAout}} & w_dec);

  assign w_c     = {{13{ir[18]}}, ir[18:0]};
  assign w_ramrd = ram[mar[MEM_AW-1:0]];

  // Lowest-numbered driver wins; R0 reached only through BAout reads as zero.
  always_comb begin
    w_rbus = '0;
    for (int i = 15; i >= 1; i--)
      if (w_rdrv[i]) w_rbus = r[i];
    if (w_rdrv[0])
      w_rbus = (R0out | (Rout & w_dec[0])) ? r[0] : '0;
  end

  always_comb begin
    bus = Mdatain;
    if      (|w_rdrv) bus = w_rbus;
    else if (HIout)   bus = hi;
    else if (LOout)   bus = lo;
    else if (ZHIout)  bus = z[2*DW-1:DW];
    else if (ZLOout)  bus = z[DW-1:0];
    else if (Pout)    bus = pc;
    else if (MDROut)  bus = mdr;
    else if (Cout)    bus = w_c;
    else if (Yout)    bus = y;
  end

  always_comb begin
    w_cond = 1'b0;
    case (ir[20:19])
      2'b00: w_cond = (bus == '0);
      2'b01: w_cond = (bus != '0);
      2'b10: w_cond = ~bus[DW-1];
      2'b11: w_cond = bus[DW-1];
      default: w_cond = 1'b0;
    endcase
  end

  data_path_alu u_alu (
    .i_op  (alu_control),
    .i_a   (y),
    .i_b   (bus),
    .o_res (w_res)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < 16; i++) r[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++)
        if (w_ren[i]) r[i] <= bus;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc  <= '0;
      ir  <= '0;
      mar <= '0;
      mdr <= '0;
      y   <= '0;
      z   <= '0;
      hi  <= '0;
      lo  <= '0;
      con <= 1'b0;
    end else begin
      if (Pen)   pc  <= bus;
      if (IRen)  ir  <= bus;
      if (MARen) mar <= bus;
      if (MDRen) mdr <= Read ? w_ramrd : bus;
      if (Yen)   y   <= bus;
      if (ZLOen) z[DW-1:0] <= w_res[DW-1:0];
      if (ZHIen) z[2*DW-1:DW] <= w_res[2*DW-1:DW];
      if (HIen)  hi  <= bus;
      if (LOen)  lo  <= bus;
      if (ConIn) con <= w_cond;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (Write) ram[mar[MEM_AW-1:0]] <= mdr;
  end

  assign w_unused = ^{ir[31:27], mar[DW-1:MEM_AW]};

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: table-driven ALU/CON vectors
// plus hand sequences for reset, fetch, store and async reset.
module tb_data_path;

  logic        clk = 1'b0;
  logic        clr;
  logic [4:0]  alu_control;
  logic [31:0] Mdatain;
  logic [15:0] rout_v, ren_v;
  logic MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout;
  logic IRen, MARen, MDRen, Yen, Pen, ZHIen, ZLOen, HIen, LOen;
  logic Read, Write, Gra, Grb, Grc, BAout, ConIn, Rin, Rout;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_path dut (
    .clk(clk), .clr(clr), .alu_control(alu_control), .Mdatain(Mdatain),
    .R0out(rout_v[0]),   .R1out(rout_v[1]),   .R2out(rout_v[2]),   .R3out(rout_v[3]),
    .R4out(rout_v[4]),   .R5out(rout_v[5]),   .R6out(rout_v[6]),   .R7out(rout_v[7]),
    .R8out(rout_v[8]),   .R9out(rout_v[9]),   .R10out(rout_v[10]), .R11out(rout_v[11]),
    .R12out(rout_v[12]), .R13out(rout_v[13]), .R14out(rout_v[14]), .R15out(rout_v[15]),
    .MDROut(MDROut), .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout),
    .ZLOout(ZLOout), .Pout(Pout), .Cout(Cout), .Yout(Yout),
    .IRen(IRen), .MARen(MARen), .MDRen(MDRen), .Yen(Yen), .Pen(Pen),
    .ZHIen(ZHIen), .ZLOen(ZLOen), .HIen(HIen), .LOen(LOen),
    .Read(Read), .Write(Write),
    .R0en(ren_v[0]),   .R1en(ren_v[1]),   .R2en(ren_v[2]),   .R3en(ren_v[3]),
    .R4en(ren_v[4]),   .R5en(ren_v[5]),   .R6en(ren_v[6]),   .R7en(ren_v[7]),
    .R8en(ren_v[8]),   .R9en(ren_v[9]),   .R10en(ren_v[10]), .R11en(ren_v[11]),
    .R12en(ren_v[12]), .R13en(ren_v[13]), .R14en(ren_v[14]), .R15en(ren_v[15]),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .BAout(BAout), .ConIn(ConIn),
    .Rin(Rin), .Rout(Rout)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } alu_vec_t;

  typedef struct {
    logic [1:0]  c2;
    logic [31:0] bus;
    logic        exp;
  } con_vec_t;

  alu_vec_t av[18];
  con_vec_t cv[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    alu_control = 5'd0;
    rout_v = '0; ren_v = '0;
    {MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout} = '0;
    {IRen, MARen, MDRen, Yen, Pen, ZHIen, ZLOen, HIen, LOen} = '0;
    {Read, Write, Gra, Grb, Grc, BAout, ConIn, Rin, Rout} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic ram_wr(input logic [31:0] addr, input logic [31:0] data);
    Mdatain = addr; MARen = 1'b1; tick();
    Mdatain = data; MDRen = 1'b1; tick();
    Write = 1'b1; tick();
  endtask

  task automatic check_zero(input string pfx);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_r%0d", pfx, i), {32'd0, dut.r[i]}, 64'd0);
    chk({pfx, "_pc"},  {32'd0, dut.pc},  64'd0);
    chk({pfx, "_ir"},  {32'd0, dut.ir},  64'd0);
    chk({pfx, "_mar"}, {32'd0, dut.mar}, 64'd0);
    chk({pfx, "_mdr"}, {32'd0, dut.mdr}, 64'd0);
    chk({pfx, "_y"},   {32'd0, dut.y},   64'd0);
    chk({pfx, "_z"},   dut.z,            64'd0);
    chk({pfx, "_hi"},  {32'd0, dut.hi},  64'd0);
    chk({pfx, "_lo"},  {32'd0, dut.lo},  64'd0);
    chk({pfx, "_con"}, {63'd0, dut.con}, 64'd0);
  endtask

  // Store flow: Y<=base, Z<=Y+C, MAR<=Z, MDR<=Ra, RAM[MAR]<=MDR.
  task automatic store_flow();
    Grb = 1'b1; BAout = 1'b1; Yen = 1'b1; tick();
    Cout = 1'b1; alu_control = 5'b00011; ZLOen = 1'b1; tick();
    ZLOout = 1'b1; MARen = 1'b1; tick();
    Gra = 1'b1; Rout = 1'b1; MDRen = 1'b1; tick();
    Write = 1'b1; tick();
  endtask

  initial begin
    av[0]  = '{5'b00011, 32'd5,         32'd7,         64'd12};
    av[1]  = '{5'b00000, 32'h7FFF_FFFF, 32'd1,         64'hFFFF_FFFF_8000_0000};
    av[2]  = '{5'b00100, 32'd3,         32'd5,         64'hFFFF_FFFF_FFFF_FFFE};
    av[3]  = '{5'b00101, 32'h8000_0000, 32'd4,         64'h0000_0000_0800_0000};
    av[4]  = '{5'b00110, 32'h8000_0000, 32'd4,         64'hFFFF_FFFF_F800_0000};
    av[5]  = '{5'b00111, 32'd3,         32'd33,        64'd6};
    av[6]  = '{5'b01000, 32'h1234_5678, 32'd8,         64'h0000_0000_7812_3456};
    av[7]  = '{5'b01001, 32'h1234_5678, 32'd4,         64'h0000_0000_2345_6781};
    av[8]  = '{5'b01010, 32'hF0F0_F0F0, 32'hFF00_FF00, 64'hFFFF_FFFF_F000_F000};
    av[9]  = '{5'b01110, 32'h0F0F_0000, 32'h0000_00FF, 64'h0000_0000_0F0F_00FF};
    av[10] = '{5'b10001, 32'd0,         32'd5,         64'hFFFF_FFFF_FFFF_FFFB};
    av[11] = '{5'b10010, 32'd0,         32'h0000_FFFF, 64'hFFFF_FFFF_FFFF_0000};
    av[12] = '{5'b01111, 32'd7,         32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
    av[13] = '{5'b01111, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
    av[14] = '{5'b10000, 32'd7,         32'd2,         64'h0000_0001_0000_0003};
    av[15] = '{5'b10000, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD};
    av[16] = '{5'b10000, 32'd7,         32'd0,         64'd0};
    av[17] = '{5'b10011, 32'd7,         32'd9,         64'd0};

    cv[0] = '{2'b00, 32'd0,         1'b1};
    cv[1] = '{2'b00, 32'd5,         1'b0};
    cv[2] = '{2'b01, 32'd0,         1'b0};
    cv[3] = '{2'b01, 32'd5,         1'b1};
    cv[4] = '{2'b10, 32'h7FFF_FFFF, 1'b1};
    cv[5] = '{2'b10, 32'h8000_0000, 1'b0};
    cv[6] = '{2'b11, 32'h8000_0000, 1'b1};
    cv[7] = '{2'b11, 32'd1,         1'b0};

    idle();
    Mdatain = '0;
    clr = 1'b1;
    #2 clr = 1'b0;
    #2 check_zero("rst");
    #4 clr = 1'b1;

    Mdatain = 32'hDEAD_BEEF;
    repeat (3) tick();
    check_zero("idle");
    chk("bus_idle", {32'd0, dut.bus}, 64'h0000_0000_DEAD_BEEF);

    // Fetch
    ram_wr(32'd0, 32'h1291_0054);
    Mdatain = 32'd0; MDRen = 1'b1; tick();
    Pout = 1'b1; MARen = 1'b1; tick();
    chk("fetch_mar", {32'd0, dut.mar}, 64'd0);
    Read = 1'b1; MDRen = 1'b1; tick();
    chk("fetch_mdr", {32'd0, dut.mdr}, 64'h1291_0054);
    MDROut = 1'b1; IRen = 1'b1; tick();
    chk("fetch_ir", {32'd0, dut.ir}, 64'h1291_0054);

    // Store with R2 base: 0x10 + 0x10054 -> RAM[0x064]
    Mdatain = 32'h10; ren_v[2] = 1'b1; tick();
    Mdatain = 32'hAB; ren_v[5] = 1'b1; tick();
    store_flow();
    chk("st_y", {32'd0, dut.y}, 64'h10);
    chk("st_mar", {32'd0, dut.mar}, 64'h1_0064);
    chk("st_ram", {32'd0, dut.ram[9'h064]}, 64'hAB);

    // Store with R0 base: BAout must give 0, not R0
    Mdatain = 32'h100; ren_v[0] = 1'b1; tick();
    Mdatain = 32'h1281_0054; IRen = 1'b1; tick();
    Mdatain = 32'hCD; ren_v[5] = 1'b1; tick();
    store_flow();
    chk("st0_y", {32'd0, dut.y}, 64'd0);
    chk("st0_ram", {32'd0, dut.ram[9'h054]}, 64'hCD);
    Grb = 1'b1; Rout = 1'b1; Yen = 1'b1; tick();
    chk("rout_r0", {32'd0, dut.y}, 64'h100);

    // HI/LO and bus priority HI > LO
    Mdatain = 32'h1111; HIen = 1'b1; tick();
    Mdatain = 32'h2222; LOen = 1'b1; tick();
    HIout = 1'b1; LOout = 1'b1; ren_v[7] = 1'b1; tick();
    chk("prio_hi", {32'd0, dut.r[7]}, 64'h1111);
    LOout = 1'b1; ren_v[8] = 1'b1; tick();
    chk("lo_out", {32'd0, dut.r[8]}, 64'h2222);

    for (int i = 0; i < 18; i++) begin
      Mdatain = av[i].a; Yen = 1'b1; tick();
      Mdatain = av[i].b; alu_control = av[i].op;
      ZHIen = 1'b1; ZLOen = 1'b1; tick();
      chk($sformatf("alu%0d_op%b", i, av[i].op), dut.z, av[i].exp);
    end

    for (int i = 0; i < 8; i++) begin
      Mdatain = {11'd0, cv[i].c2, 19'd0}; IRen = 1'b1; tick();
      Mdatain = cv[i].bus; ConIn = 1'b1; tick();
      chk($sformatf("con%0d", i), {63'd0, dut.con}, {63'd0, cv[i].exp});
    end

    // Async reset between edges
    @(posedge clk);
    #3 clr = 1'b0;
    #1 check_zero("async");
    chk("async_ram64", {32'd0, dut.ram[9'h064]}, 64'hAB);
    chk("async_ram54", {32'd0, dut.ram[9'h054]}, 64'hCD);
    chk("async_ram0",  {32'd0, dut.ram[9'h000]}, 64'h1291_0054);
    #10 clr = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
